// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// One transaction in flight: IDLE accepts, REQ presents to memory, WAIT collects the reply.
module mem_arbiter #(
  parameter int XLEN           = 64,
  parameter int MAX_LSU_STREAK = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [XLEN-1:0] ifu_addr,
  output logic            ifu_rsp_valid,
  output logic [XLEN-1:0] ifu_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic            lsu_wen,
  input  logic [XLEN-1:0] lsu_wdata,
  input  logic [7:0]      lsu_wmask,
  output logic            lsu_rsp_valid,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [7:0]      mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            timeout_err
);

  localparam int SW = $clog2(MAX_LSU_STREAK + 1);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);
  localparam logic [CW-1:0] CNT_MAX    = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              grant_ifu_s;
  logic              grant_lsu_s;
  logic              rsp_done_s;
  logic              timeout_s;
  logic [XLEN-1:0]   rsp_data_s;

  logic              owner_lsu_r;
  logic [XLEN-1:0]   addr_r;
  logic              wen_r;
  logic [XLEN-1:0]   wdata_r;
  logic [7:0]        wmask_r;
  logic [SW-1:0]     streak_r;
  logic [CW-1:0]     cnt_r;
  logic              ifu_rsp_valid_r;
  logic              lsu_rsp_valid_r;
  logic [XLEN-1:0]   ifu_rdata_r;
  logic [XLEN-1:0]   lsu_rdata_r;
  logic              timeout_err_r;

  // Grant decision, next state and WAIT exit conditions.
  always_comb begin
    state_s     = state_r;
    grant_ifu_s = 1'b0;
    grant_lsu_s = 1'b0;
    rsp_done_s  = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // IFU is forced through once LSU has used up its streak while IFU waited.
        if (lsu_req_valid && !(ifu_req_valid && (streak_r == STREAK_MAX))) begin
          grant_lsu_s = 1'b1;
          state_s     = ST_REQ;
        end else if (ifu_req_valid) begin
          grant_ifu_s = 1'b1;
          state_s     = ST_REQ;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          rsp_done_s = 1'b1;
          state_s    = ST_IDLE;
        end else if (cnt_r == CNT_MAX) begin
          rsp_done_s = 1'b1;
          timeout_s  = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s    = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (timeout_s || wen_r) begin
      rsp_data_s = {XLEN{1'b0}};
    end else begin
      rsp_data_s = mem_rdata;
    end
  end

  assign ifu_req_ready = grant_ifu_s & ~rst;
  assign lsu_req_ready = grant_lsu_s & ~rst;
  assign mem_req_valid = (state_r == ST_REQ);
  assign mem_addr      = addr_r;
  assign mem_wen       = wen_r;
  assign mem_wdata     = wdata_r;
  assign mem_wmask     = wmask_r;
  assign ifu_rsp_valid = ifu_rsp_valid_r;
  assign lsu_rsp_valid = lsu_rsp_valid_r;
  assign ifu_rdata     = ifu_rdata_r;
  assign lsu_rdata     = lsu_rdata_r;
  assign timeout_err   = timeout_err_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch the winning request; IFU and loads never carry write data or mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_lsu_r <= 1'b0;
      addr_r      <= {XLEN{1'b0}};
      wen_r       <= 1'b0;
      wdata_r     <= {XLEN{1'b0}};
      wmask_r     <= 8'h00;
    end else if (grant_lsu_s) begin
      owner_lsu_r <= 1'b1;
      addr_r      <= lsu_addr;
      wen_r       <= lsu_wen;
      wdata_r     <= lsu_wen ? lsu_wdata : {XLEN{1'b0}};
      wmask_r     <= lsu_wen ? lsu_wmask : 8'h00;
    end else if (grant_ifu_s) begin
      owner_lsu_r <= 1'b0;
      addr_r      <= ifu_addr;
      wen_r       <= 1'b0;
      wdata_r     <= {XLEN{1'b0}};
      wmask_r     <= 8'h00;
    end
  end

  // LSU streak counter and WAIT timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_r <= {SW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (grant_lsu_s && (streak_r != STREAK_MAX)) begin
        streak_r <= streak_r + SW'(1);
      end else if (grant_ifu_s) begin
        streak_r <= {SW{1'b0}};
      end
      if ((state_r == ST_REQ) && mem_req_ready) begin
        cnt_r <= {CW{1'b0}};
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Registered response pulse to the owner; rdata holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_rsp_valid_r <= 1'b0;
      lsu_rsp_valid_r <= 1'b0;
      ifu_rdata_r     <= {XLEN{1'b0}};
      lsu_rdata_r     <= {XLEN{1'b0}};
      timeout_err_r   <= 1'b0;
    end else begin
      ifu_rsp_valid_r <= rsp_done_s & ~owner_lsu_r;
      lsu_rsp_valid_r <= rsp_done_s & owner_lsu_r;
      timeout_err_r   <= timeout_s;
      if (rsp_done_s && owner_lsu_r) begin
        lsu_rdata_r <= rsp_data_s;
      end else if (rsp_done_s) begin
        ifu_rdata_r <= rsp_data_s;
      end
    end
  end

endmodule
